// File: rtl/write_ptr_full.sv
// rtl/write_ptr_full.sv - FIFO write-side pointer, full/almost-full flags and occupancy
// Optional saturating overflow counter enabled by WPTR_OVERFLOW_CNT_EN.
module write_ptr_full #(
    parameter int Addr_Width = 8
) (
    input  logic                wrclk,
    input  logic                wr_rst_n,
    input  logic                wr_en,
    input  logic [Addr_Width:0] rptr_sync,
    input  logic [Addr_Width:0] afull_thresh,
    output logic [Addr_Width:0] wraddr,
    output logic [Addr_Width:0] wptr,
    output logic                full,
    output logic                almost_full,
    output logic [Addr_Width:0] wr_level,
    output logic                wr_ack,
    output logic                overflow,
    output logic [15:0]         ovf_count
);

    localparam int PtrW = Addr_Width + 1;

    logic [Addr_Width:0] waddr_q, waddr_d;
    logic [Addr_Width:0] wptr_q, wptr_d;
    logic [Addr_Width:0] level_q, level_d;
    logic                full_q, full_d;
    logic                afull_q, afull_d;
    logic                wr_ack_q, wr_ack_d;
    logic                overflow_q, overflow_d;
    logic                accept;
    logic [Addr_Width:0] rbin;
    logic [Addr_Width:0] rptr_wrapped;

    always_comb begin
        accept       = wr_en & ~full_q;
        waddr_d      = waddr_q + {{Addr_Width{1'b0}}, accept};
        wptr_d       = (waddr_d >> 1) ^ waddr_d;
        // Each binary bit is the XOR of all Gray bits at and above it.
        rbin         = '0;
        for (int i = 0; i < PtrW; i++) begin
            rbin[i] = ^(rptr_sync >> i);
        end
        // Full when write pointer is one lap ahead: top two Gray bits inverted.
        rptr_wrapped = {~rptr_sync[Addr_Width:Addr_Width-1], rptr_sync[Addr_Width-2:0]};
        full_d       = (wptr_d == rptr_wrapped);
        level_d      = waddr_d - rbin;
        afull_d      = (level_d >= afull_thresh);
        wr_ack_d     = accept;
        overflow_d   = wr_en & full_q;
    end

    always_ff @(posedge wrclk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            waddr_q    <= '0;
            wptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            wptr_q     <= wptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            wr_ack_q   <= wr_ack_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef WPTR_OVERFLOW_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Counts alongside the overflow pulse so both update on the same edge.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (overflow_d && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wrclk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 16'd0;
`endif

    assign wraddr      = waddr_q;
    assign wptr        = wptr_q;
    assign wr_level    = level_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_write_ptr_full.sv
// tb/tb_write_ptr_full.sv - directed vectors plus randomized model check for write_ptr_full
module tb_write_ptr_full;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef WPTR_OVERFLOW_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          wrclk = 1'b0;
    logic          wr_rst_n;
    logic          wr_en;
    logic [AW:0]   rptr_sync;
    logic [AW:0]   afull_thresh;
    logic [AW:0]   wraddr, wptr, wr_level;
    logic          full, almost_full, wr_ack, overflow;
    logic [15:0]   ovf_count;

    int n_tests = 0;
    int n_fail  = 0;

    write_ptr_full #(.Addr_Width(AW)) dut (
        .wrclk(wrclk), .wr_rst_n(wr_rst_n), .wr_en(wr_en),
        .rptr_sync(rptr_sync), .afull_thresh(afull_thresh),
        .wraddr(wraddr), .wptr(wptr), .full(full), .almost_full(almost_full),
        .wr_level(wr_level), .wr_ack(wr_ack), .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 wrclk = ~wrclk;

    typedef struct {
        logic       wr_en;
        int         rd_bin;
        int         exp_waddr;
        int         exp_wptr;
        logic       exp_full;
        logic       exp_afull;
        int         exp_level;
        logic       exp_ack;
        logic       exp_ovf;
        int         exp_ovfcnt;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = AW'(0) + b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst_n = 1'b0;
        wr_en    = 1'b0;
        rptr_sync = '0;
        #12;
        @(negedge wrclk);
        wr_rst_n = 1'b1;
    endtask

    int m_w, m_r, m_ovf;
    logic m_full;

    initial begin
        afull_thresh = 4'd6;
        do_reset();
        check("reset_wraddr", wraddr, 0);
        check("reset_wptr", wptr, 0);
        check("reset_full", full, 0);
        check("reset_level", wr_level, 0);
        tick();
        check("idle_wraddr", wraddr, 0);
        check("idle_full", full, 0);

        // Fill to full, overflow three times, free two slots, write one more.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 0, i + 1, (i + 1) ^ ((i + 1) >> 1), (i == 7), (i + 1 >= 6), i + 1, 1'b1, 1'b0, 0};
        for (int i = 8; i < 11; i++)
            vecs[i] = '{1'b1, 0, 8, 12, 1'b1, 1'b1, 8, 1'b0, 1'b1, CNT_EN ? i - 7 : 0};
        vecs[11] = '{1'b0, 2, 8, 12, 1'b0, 1'b1, 6, 1'b0, 1'b0, CNT_EN ? 3 : 0};
        vecs[12] = '{1'b1, 2, 9, 13, 1'b0, 1'b1, 7, 1'b1, 1'b0, CNT_EN ? 3 : 0};

        for (int i = 0; i < 13; i++) begin
            wr_en     = vecs[i].wr_en;
            rptr_sync = to_gray(vecs[i].rd_bin);
            tick();
            check($sformatf("v%0d_wraddr", i), wraddr, vecs[i].exp_waddr);
            check($sformatf("v%0d_wptr", i), wptr, vecs[i].exp_wptr);
            check($sformatf("v%0d_full", i), full, vecs[i].exp_full);
            check($sformatf("v%0d_afull", i), almost_full, vecs[i].exp_afull);
            check($sformatf("v%0d_level", i), wr_level, vecs[i].exp_level);
            check($sformatf("v%0d_ack", i), wr_ack, vecs[i].exp_ack);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
            check($sformatf("v%0d_ovfcnt", i), ovf_count, vecs[i].exp_ovfcnt);
        end

        // Zero threshold: almost_full from the first edge after reset.
        afull_thresh = 4'd0;
        do_reset();
        check("thr0_reset_afull", almost_full, 0);
        tick();
        check("thr0_first_edge_afull", almost_full, 1);

        // Randomized run against an occupancy-count model, reads trailing writes.
        afull_thresh = 4'd5;
        do_reset();
        m_w = 0; m_r = 0; m_ovf = 0; m_full = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic we;
            logic acc;
            int lvl;
            we = ($urandom_range(0, 99) < 60);
            if ((m_w - m_r) > 0 && $urandom_range(0, 99) < 45) m_r++;
            wr_en     = we;
            rptr_sync = to_gray(m_r % 16);
            acc = we && !m_full;
            if (acc) m_w++;
            if (we && m_full && m_ovf < 65535) m_ovf++;
            lvl = m_w - m_r;
            tick();
            check("rnd_wraddr", wraddr, m_w % 16);
            check("rnd_wptr", wptr, to_gray(m_w % 16));
            check("rnd_level", wr_level, lvl);
            check("rnd_full", full, lvl == DEPTH);
            check("rnd_afull", almost_full, lvl >= 5);
            check("rnd_ack", wr_ack, acc);
            check("rnd_ovf", overflow, we && m_full);
            check("rnd_ovfcnt", ovf_count, CNT_EN ? m_ovf : 0);
            m_full = (lvl == DEPTH);
        end

        // Asynchronous reset mid-fill at level 5, then restart from zero.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        check("pre_rst_level", wr_level, 5);
        #2;
        wr_rst_n = 1'b0;
        #1;
        check("async_wraddr", wraddr, 0);
        check("async_wptr", wptr, 0);
        check("async_full", full, 0);
        check("async_afull", almost_full, 0);
        check("async_level", wr_level, 0);
        check("async_ack", wr_ack, 0);
        check("async_ovf", overflow, 0);
        check("async_ovfcnt", ovf_count, 0);
        @(negedge wrclk);
        wr_rst_n = 1'b1;
        wr_en    = 1'b1;
        tick();
        check("post_rst_wraddr", wraddr, 1);
        check("post_rst_level", wr_level, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
